// File: rtl/wb_merge_queue.sv
// Multi-channel writeback merge queue: round-robin accept over four-phase links, in-order drain to RF.
// Optional youngest-entry forwarding lookup is enabled by defining WB_FWD_EN.
module wb_merge_queue #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH-1:0]            in_req,
    output logic [NUM_CH-1:0]            in_ack,
    input  logic [NUM_CH*ADDR_W-1:0]     in_rd,
    input  logic [NUM_CH*DATA_W-1:0]     in_data,
    input  logic [NUM_CH-1:0]            in_wen,
    output logic                         rf_req,
    input  logic                         rf_ack,
    output logic                         rf_we,
    output logic [ADDR_W-1:0]            rf_addr,
    output logic [DATA_W-1:0]            rf_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
`ifdef WB_FWD_EN
   ,input  logic [ADDR_W-1:0]            fwd_addr,
    output logic                         fwd_hit,
    output logic [DATA_W-1:0]            fwd_data
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned RR_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {StIdle, StReq, StWaitLow} state_e;

    state_e              r_state;
    logic [NUM_CH-1:0]   r_ack;
    logic [RR_W-1:0]     r_rr;
    logic [PTR_W-1:0]    r_head;
    logic [PTR_W-1:0]    r_tail;
    logic [CNT_W-1:0]    r_count;
    logic                r_rf_req;
    logic [ADDR_W-1:0]   r_rf_addr;
    logic [DATA_W-1:0]   r_rf_data;
    logic [ADDR_W-1:0]   r_mem_addr [DEPTH];
    logic [DATA_W-1:0]   r_mem_data [DEPTH];

    logic                w_full;
    logic                w_empty;
    logic [NUM_CH-1:0]   w_elig;
    logic                w_gnt_vld;
    logic [RR_W-1:0]     w_gnt_idx;
    logic                w_push;
    logic                w_pop;
    logic [ADDR_W-1:0]   w_push_addr;
    logic [DATA_W-1:0]   w_push_data;
    logic [NUM_CH-1:0]   w_ack_d;

    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);
    // Discards never need queue space, so only writes are blocked by full.
    assign w_elig  = in_req & ~r_ack & (~in_wen | {NUM_CH{~w_full}});
    assign w_pop   = (r_state == StReq) && rf_ack;

    // Round-robin: scan from r_rr upward, then wrap to the channels below it.
    always_comb begin
        w_gnt_vld   = 1'b0;
        w_gnt_idx   = '0;
        w_push      = 1'b0;
        w_push_addr = '0;
        w_push_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!w_gnt_vld && w_elig[i] && (i >= int'(r_rr))) begin
                w_gnt_vld   = 1'b1;
                w_gnt_idx   = RR_W'(i);
                w_push      = in_wen[i];
                w_push_addr = in_rd[i*ADDR_W +: ADDR_W];
                w_push_data = in_data[i*DATA_W +: DATA_W];
            end
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (!w_gnt_vld && w_elig[i] && (i < int'(r_rr))) begin
                w_gnt_vld   = 1'b1;
                w_gnt_idx   = RR_W'(i);
                w_push      = in_wen[i];
                w_push_addr = in_rd[i*ADDR_W +: ADDR_W];
                w_push_data = in_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        w_ack_d = r_ack;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_gnt_vld && (w_gnt_idx == RR_W'(i))) begin
                w_ack_d[i] = 1'b1;
            end else if (!in_req[i]) begin
                w_ack_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ack   <= '0;
            r_rr    <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_ack <= w_ack_d;
            if (w_gnt_vld) begin
                r_rr <= (w_gnt_idx == RR_W'(NUM_CH - 1)) ? '0 : w_gnt_idx + 1'b1;
            end
            if (w_push) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_head <= r_head + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_addr[r_tail] <= w_push_addr;
            r_mem_data[r_tail] <= w_push_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= StIdle;
            r_rf_req  <= 1'b0;
            r_rf_addr <= '0;
            r_rf_data <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (!w_empty && !rf_ack) begin
                        r_state   <= StReq;
                        r_rf_req  <= 1'b1;
                        r_rf_addr <= r_mem_addr[r_head];
                        r_rf_data <= r_mem_data[r_head];
                    end
                end
                StReq: begin
                    if (rf_ack) begin
                        r_state  <= StWaitLow;
                        r_rf_req <= 1'b0;
                    end
                end
                StWaitLow: begin
                    if (!rf_ack) begin
                        r_state <= StIdle;
                    end
                end
                default: begin
                    r_state  <= StIdle;
                    r_rf_req <= 1'b0;
                end
            endcase
        end
    end

`ifdef WB_FWD_EN
    logic [PTR_W-1:0] w_fwd_idx [DEPTH];

    // Walk oldest to youngest so the last match wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_fwd_idx[k] = r_head + PTR_W'(k);
            if ((CNT_W'(k) < r_count) && (r_mem_addr[w_fwd_idx[k]] == fwd_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = r_mem_data[w_fwd_idx[k]];
            end
        end
    end
`endif

    assign in_ack  = r_ack;
    assign rf_req  = r_rf_req;
    assign rf_we   = r_rf_req;
    assign rf_addr = r_rf_addr;
    assign rf_data = r_rf_data;
    assign count   = r_count;
    assign full    = w_full;
    assign empty   = w_empty;

endmodule

// File: tb/tb_wb_merge_queue.sv
// Directed bench for wb_merge_queue; expected RF writes are queued as stimulus is driven.
module tb_wb_merge_queue;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;
    localparam int NUM_CH = 2;
    localparam int DEPTH  = 4;

    logic                       clk = 1'b0;
    logic                       rst;
    logic [NUM_CH-1:0]          in_req;
    logic [NUM_CH-1:0]          in_ack;
    logic [NUM_CH*ADDR_W-1:0]   in_rd;
    logic [NUM_CH*DATA_W-1:0]   in_data;
    logic [NUM_CH-1:0]          in_wen;
    logic                       rf_req;
    logic                       rf_ack;
    logic                       rf_we;
    logic [ADDR_W-1:0]          rf_addr;
    logic [DATA_W-1:0]          rf_data;
    logic [2:0]                 count;
    logic                       full;
    logic                       empty;
`ifdef WB_FWD_EN
    logic [ADDR_W-1:0]          fwd_addr;
    logic                       fwd_hit;
    logic [DATA_W-1:0]          fwd_data;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    logic [ADDR_W+DATA_W-1:0] sb [$];

    wb_merge_queue #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .NUM_CH (NUM_CH),
        .DEPTH  (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_req   (in_req),
        .in_ack   (in_ack),
        .in_rd    (in_rd),
        .in_data  (in_data),
        .in_wen   (in_wen),
        .rf_req   (rf_req),
        .rf_ack   (rf_ack),
        .rf_we    (rf_we),
        .rf_addr  (rf_addr),
        .rf_data  (rf_data),
        .count    (count),
        .full     (full),
        .empty    (empty)
`ifdef WB_FWD_EN
       ,.fwd_addr (fwd_addr),
        .fwd_hit  (fwd_hit),
        .fwd_data (fwd_data)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic set_ch(input int ch, input logic req, input logic [ADDR_W-1:0] rd,
                          input logic [DATA_W-1:0] d, input logic wen);
        in_rd[ch*ADDR_W +: ADDR_W]   = rd;
        in_data[ch*DATA_W +: DATA_W] = d;
        in_wen[ch]                   = wen;
        in_req[ch]                   = req;
    endtask

    task automatic wait_ack(input int ch, input logic val, input string tag);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ack[ch] === val) break;
        end
        check(tag, 32'(in_ack[ch]), 32'(val));
    endtask

    task automatic push_ch0(input logic [ADDR_W-1:0] rd, input logic [DATA_W-1:0] d);
        set_ch(0, 1'b1, rd, d, 1'b1);
        sb.push_back({rd, d});
        wait_ack(0, 1'b1, "push_ack_up");
        in_req[0] = 1'b0;
        wait_ack(0, 1'b0, "push_ack_down");
    endtask

    task automatic drain_one(input string tag);
        logic [ADDR_W+DATA_W-1:0] e;
        logic                     have;
        for (int i = 0; i < 20; i++) begin
            if (rf_req === 1'b1) break;
            @(negedge clk);
        end
        check({tag, "_req"}, 32'(rf_req), 32'd1);
        have = (sb.size() > 0);
        check({tag, "_sb"}, 32'(have), 32'd1);
        e = have ? sb.pop_front() : '1;
        check({tag, "_addr"}, 32'(rf_addr), 32'(e[ADDR_W+DATA_W-1:DATA_W]));
        check({tag, "_data"}, 32'(rf_data), 32'(e[DATA_W-1:0]));
        check({tag, "_we"}, 32'(rf_we), 32'd1);
        rf_ack = 1'b1;
        @(negedge clk);
        check({tag, "_reqdrop"}, 32'(rf_req), 32'd0);
        rf_ack = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst    = 1'b0;
        in_req = '0;
        in_wen = '0;
        rf_ack = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst     = 1'b0;
        in_req  = '0;
        in_rd   = '0;
        in_data = '0;
        in_wen  = '0;
        rf_ack  = 1'b0;
`ifdef WB_FWD_EN
        fwd_addr = '0;
`endif
        repeat (2) @(negedge clk);
        check("rst_in_ack", 32'(in_ack), 32'd0);
        check("rst_rf_req", 32'(rf_req), 32'd0);
        check("rst_rf_we", 32'(rf_we), 32'd0);
        check("rst_rf_addr", 32'(rf_addr), 32'd0);
        check("rst_rf_data", 32'(rf_data), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Single write with latency checks.
        set_ch(0, 1'b1, 4'd3, 16'h1234, 1'b1);
        sb.push_back({4'd3, 16'h1234});
        @(negedge clk);
        check("t1_ack", 32'(in_ack), 32'b01);
        check("t1_count", 32'(count), 32'd1);
        check("t1_req_early", 32'(rf_req), 32'd0);
        in_req[0] = 1'b0;
        @(negedge clk);
        check("t1_req_up", 32'(rf_req), 32'd1);
        check("t1_ack_down", 32'(in_ack), 32'd0);
        drain_one("t1");
        check("t1_count_end", 32'(count), 32'd0);
        check("t1_empty_end", 32'(empty), 32'd1);

        // Contention: ch0 wins first after reset, ch1 follows.
        do_reset();
        set_ch(0, 1'b1, 4'd1, 16'hAAAA, 1'b1);
        set_ch(1, 1'b1, 4'd2, 16'hBBBB, 1'b1);
        sb.push_back({4'd1, 16'hAAAA});
        sb.push_back({4'd2, 16'hBBBB});
        @(negedge clk);
        check("t2_ack_first", 32'(in_ack), 32'b01);
        @(negedge clk);
        check("t2_ack_second", 32'(in_ack), 32'b11);
        check("t2_count", 32'(count), 32'd2);
        in_req = '0;
        drain_one("t2a");
        drain_one("t2b");
        check("t2_empty", 32'(empty), 32'd1);

        // Full: fifth write stalls until one RF handshake completes.
        do_reset();
        for (int i = 0; i < DEPTH; i++) push_ch0(4'(i + 4), 16'hC000 + 16'(i));
        check("t3_full", 32'(full), 32'd1);
        check("t3_count", 32'(count), 32'd4);
        set_ch(0, 1'b1, 4'd9, 16'hC009, 1'b1);
        sb.push_back({4'd9, 16'hC009});
        repeat (4) @(negedge clk);
        check("t3_stall", 32'(in_ack[0]), 32'd0);
        check("t3_still_full", 32'(full), 32'd1);
        drain_one("t3_first");
        wait_ack(0, 1'b1, "t3_fifth_ack");
        check("t3_refull", 32'(count), 32'd4);
        in_req[0] = 1'b0;
        wait_ack(0, 1'b0, "t3_fifth_drop");
        for (int i = 0; i < DEPTH; i++) drain_one("t3_rest");
        check("t3_empty", 32'(empty), 32'd1);

        // Discard while full: acked at once, nothing queued.
        do_reset();
        for (int i = 0; i < DEPTH; i++) push_ch0(4'(i + 10), 16'h0D00 + 16'(i));
        set_ch(1, 1'b1, 4'd7, 16'hDEAD, 1'b0);
        @(negedge clk);
        check("t4_ack", 32'(in_ack[1]), 32'd1);
        check("t4_count", 32'(count), 32'd4);
        check("t4_full", 32'(full), 32'd1);
        in_req[1] = 1'b0;
        for (int i = 0; i < DEPTH; i++) drain_one("t4_drain");
        repeat (5) @(negedge clk);
        check("t4_no_extra", 32'(rf_req), 32'd0);
        check("t4_empty", 32'(empty), 32'd1);

        // rf_ack high while idle must not pop or start a request.
        do_reset();
        rf_ack = 1'b1;
        push_ch0(4'd2, 16'h5555);
        repeat (3) @(negedge clk);
        check("t5_no_req", 32'(rf_req), 32'd0);
        check("t5_count", 32'(count), 32'd1);
        rf_ack = 1'b0;
        drain_one("t5");

        // Reset mid-drain clears everything asynchronously.
        do_reset();
        for (int i = 0; i < 3; i++) push_ch0(4'(i + 1), 16'hE000 + 16'(i));
        check("t6_req", 32'(rf_req), 32'd1);
        check("t6_count", 32'(count), 32'd3);
        set_ch(1, 1'b1, 4'd1, 16'h0, 1'b0);
        @(negedge clk);
        check("t6_ack_held", 32'(in_ack), 32'b10);
        rst = 1'b0;
        #1;
        check("t6_rst_req", 32'(rf_req), 32'd0);
        check("t6_rst_ack", 32'(in_ack), 32'd0);
        check("t6_rst_count", 32'(count), 32'd0);
        check("t6_rst_empty", 32'(empty), 32'd1);
        sb.delete();
        in_req = '0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("t6_no_stale", 32'(rf_req), 32'd0);
        end
        check("t6_count_end", 32'(count), 32'd0);

`ifdef WB_FWD_EN
        // Forwarding returns the youngest matching entry.
        do_reset();
        push_ch0(4'd5, 16'h0011);
        fwd_addr = 4'd5;
        #1;
        check("t7_hit_one", 32'(fwd_hit), 32'd1);
        check("t7_data_one", 32'(fwd_data), 32'h0011);
        push_ch0(4'd5, 16'h0022);
        #1;
        check("t7_hit", 32'(fwd_hit), 32'd1);
        check("t7_data", 32'(fwd_data), 32'h0022);
        fwd_addr = 4'd6;
        #1;
        check("t7_miss_hit", 32'(fwd_hit), 32'd0);
        check("t7_miss_data", 32'(fwd_data), 32'd0);
        @(negedge clk);
        drain_one("t7a");
        drain_one("t7b");
        fwd_addr = 4'd5;
        #1;
        check("t7_drained", 32'(fwd_hit), 32'd0);
        @(negedge clk);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
